tx_byte_fifo: RTL and testbench

- Elastic byte buffer between the SRAM queue's transmit output and the UART transmitter.
- Absorbs bursts of bytes read back from SRAM while the UART shifts at BAUD rate, so the queue does not stall on every byte.
- Uses the same en/ack byte handshake on both sides.
- Upstream producer is the queue (tx_data/tx_en/tx_ack); downstream consumer is uart_tx (data_in/en/ack).

---
 rtl/tx_byte_fifo.sv | 133 +++++++++++++
 tb/tb_tx_byte_fifo.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_byte_fifo.sv
// tx_byte_fifo: elastic byte buffer between the SRAM queue transmit output
// and the UART transmitter. A 2^DEPTH_LOG2-byte circular memory feeds a
// one-byte registered output stage; both sides use an en/ack byte handshake.
// Optional feature macro: TX_FIFO_CRLF_EN -- when defined, every 0x0A leaving
// the output stage is presented as 0x0D followed by 0x0A (one memory read).
module tx_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  in_en,
  input  logic [7:0]            in_data,
  output logic                  in_ack,
  output logic                  out_en,
  output logic [7:0]            out_data,
  input  logic                  out_ack,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0] CNT_ZERO  = (DEPTH_LOG2 + 1)'(0);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  in_ack_q, in_ack_d;
  logic                  out_en_q, out_en_d;
  logic [7:0]            out_data_q, out_data_d;
  logic                  accept_s;
  logic                  load_s;
  logic                  full_s;
  logic [7:0]            rd_byte_s;
`ifdef TX_FIFO_CRLF_EN
  logic                  lf_pending_q, lf_pending_d;
`endif

  // Next-state logic: accept guard, output-stage load/pop, pointer and count update.
  always_comb begin
    full_s     = (cnt_q == DEPTH_CNT);
    // The in_ack_q term blocks a second write while the producer is still
    // dropping in_en after seeing the previous ack.
    accept_s   = in_en & ~in_ack_q & ~full_s;
    rd_byte_s  = mem_q[rd_ptr_q];
    in_ack_d   = accept_s;
    out_en_d   = out_en_q;
    out_data_d = out_data_q;
    rd_ptr_d   = rd_ptr_q;
    load_s     = 1'b0;
`ifdef TX_FIFO_CRLF_EN
    lf_pending_d = lf_pending_q;
    // The 0x0D stand-in was taken: present the held 0x0A without a memory read.
    if (out_en_q && out_ack && lf_pending_q) begin
      out_data_d   = 8'h0A;
      lf_pending_d = 1'b0;
    end else
`endif
    if ((!out_en_q || out_ack) && (cnt_q != CNT_ZERO)) begin
      load_s   = 1'b1;
      out_en_d = 1'b1;
      rd_ptr_d = rd_ptr_q + 1'b1;
`ifdef TX_FIFO_CRLF_EN
      if (rd_byte_s == 8'h0A) begin
        out_data_d   = 8'h0D;
        lf_pending_d = 1'b1;
      end else begin
        out_data_d   = rd_byte_s;
      end
`else
      out_data_d = rd_byte_s;
`endif
    end else if (out_ack) begin
      // Popped with nothing behind it; out_data keeps its last value.
      out_en_d = 1'b0;
    end else begin
      out_en_d = out_en_q;
    end

    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({accept_s, load_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; asynchronous reset discards everything held.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      in_ack_q     <= 1'b0;
      out_en_q     <= 1'b0;
      out_data_q   <= 8'h00;
`ifdef TX_FIFO_CRLF_EN
      lf_pending_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      in_ack_q     <= in_ack_d;
      out_en_q     <= out_en_d;
      out_data_q   <= out_data_d;
`ifdef TX_FIFO_CRLF_EN
      lf_pending_q <= lf_pending_d;
`endif
    end
  end

  // Byte storage; contents are don't-care after reset so it has no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ack   = in_ack_q;
  assign out_en   = out_en_q;
  assign out_data = out_data_q;
  assign full     = full_s;
  assign level    = cnt_q + {{DEPTH_LOG2{1'b0}}, out_en_q};

endmodule

// File: tb/tb_tx_byte_fifo.sv
// Self-checking bench for tx_byte_fifo: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_tx_byte_fifo;

  localparam int DL = 4;
  localparam int DEPTH = 1 << DL;
`ifdef TX_FIFO_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic         clk = 1'b0;
  logic         reset_;
  logic         in_en;
  logic [7:0]   in_data;
  logic         in_ack;
  logic         out_en;
  logic [7:0]   out_data;
  logic         out_ack;
  logic [DL:0]  level;
  logic         full;

  tx_byte_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset_(reset_), .in_en(in_en), .in_data(in_data),
    .in_ack(in_ack), .out_en(out_en), .out_data(out_data), .out_ack(out_ack),
    .level(level), .full(full)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ack_mode = 0;   // 0 hold low, 1 random, 2 every 3rd cycle, 3 take whenever valid, 4 manual

  // reference model state
  bq_t        memq;
  bit         m_in_ack;
  bit         m_oen;
  logic [7:0] m_od;
  bit         m_lf;

  bq_t src;      // bytes the producer still has to deliver
  bq_t dut_rx;   // bytes the consumer took from the DUT

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bq_t expand(input bq_t q);
    bq_t r;
    foreach (q[i]) begin
      if (CRLF && q[i] == 8'h0A) r.push_back(8'h0D);
      r.push_back(q[i]);
    end
    return r;
  endfunction

  task automatic check_seq(input string name, input bq_t exp);
    check({name, "_len"}, dut_rx.size(), exp.size());
    for (int i = 0; i < exp.size() && i < dut_rx.size(); i++)
      check(name, dut_rx[i], exp[i]);
  endtask

  function automatic void model_reset();
    memq.delete();
    m_in_ack = 1'b0;
    m_oen    = 1'b0;
    m_od     = 8'h00;
    m_lf     = 1'b0;
  endfunction

  // One clock edge of the spec rules, using the inputs held before the edge.
  function automatic void model_step();
    bit acc;
    logic [7:0] b;
    if (!reset_) begin
      model_reset();
      return;
    end
    acc = in_en && !m_in_ack && (memq.size() < DEPTH);
    if (m_lf && m_oen && out_ack) begin
      m_od = 8'h0A;
      m_lf = 1'b0;
    end else if ((!m_oen || out_ack) && memq.size() > 0) begin
      b = memq.pop_front();
      if (CRLF && b == 8'h0A) begin
        m_od = 8'h0D;
        m_lf = 1'b1;
      end else begin
        m_od = b;
      end
      m_oen = 1'b1;
    end else if (out_ack) begin
      m_oen = 1'b0;
    end
    if (acc) memq.push_back(in_data);
    m_in_ack = acc;
  endfunction

  task automatic compare_all();
    check("in_ack", in_ack, m_in_ack);
    check("out_en", out_en, m_oen);
    check("out_data", out_data, m_od);
    check("level", level, memq.size() + int'(m_oen));
    check("full", full, memq.size() == DEPTH);
  endtask

  task automatic drive_inputs();
    in_en   = src.size() > 0;
    in_data = (src.size() > 0) ? src[0] : 8'($urandom);
    case (ack_mode)
      0:       out_ack = 1'b0;
      1:       out_ack = 1'($urandom_range(0, 1));
      2:       out_ack = (cyc % 3 == 0);
      3:       out_ack = m_oen;
      default: ;
    endcase
  endtask

  task automatic tick();
    if (out_ack && out_en) dut_rx.push_back(out_data);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    cyc++;
    if (m_in_ack && src.size() > 0) void'(src.pop_front());
    drive_inputs();
  endtask

  task automatic drain(input int budget);
    bit done = 1'b0;
    ack_mode = 3;
    drive_inputs();
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = (src.size() == 0) && (memq.size() == 0) && !m_oen && !m_in_ack;
    end
    check("drain_timeout", done, 1'b1);
  endtask

  task automatic pulse_ack();
    ack_mode = 4;
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t exp;
    bq_t sent;
    bit full_seen;
    int guard;
    logic [7:0] b;

    reset_ = 1'b0; in_en = 1'b0; in_data = 8'h00; out_ack = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    // reset state, literal expectations
    check("rst_in_ack", in_ack, 1'b0);
    check("rst_out_en", out_en, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_level", level, 0);
    check("rst_full", full, 1'b0);
    reset_ = 1'b1;

    // single byte
    dut_rx.delete();
    src.push_back(8'h41);
    ack_mode = 0;
    drive_inputs();
    tick();
    check("single_in_ack", in_ack, 1'b1);
    tick();
    check("single_out_en", out_en, 1'b1);
    check("single_out_data", out_data, 8'h41);
    check("single_in_ack_drop", in_ack, 1'b0);
    pulse_ack();
    check("single_out_en_after", out_en, 1'b0);
    check("single_level_after", level, 0);
    exp.delete(); exp.push_back(8'h41);
    check_seq("single_seq", exp);

    // fill with the consumer stalled
    dut_rx.delete(); sent.delete();
    for (int i = 0; i <= 8'h11; i++) begin
      src.push_back(8'(i));
      sent.push_back(8'(i));
    end
    ack_mode = 0;
    drive_inputs();
    repeat (40) tick();
    check("fill_level", level, 17);
    check("fill_full", full, 1'b1);
    check("fill_out_data", out_data, 8'h00);
    check("fill_no_ack", in_ack, 1'b0);
    pulse_ack();
    ack_mode = 0;
    tick(); tick();
    check("fill_level_refill", level, 17);
    check("fill_full_refill", full, 1'b1);
    drain(300);
    check_seq("fill_seq", expand(sent));

    // wrap-around with a slow consumer
    dut_rx.delete(); sent.delete();
    for (int i = 8'h20; i <= 8'h47; i++) begin
      src.push_back(8'(i));
      sent.push_back(8'(i));
    end
    ack_mode = 2;
    full_seen = 1'b0;
    drive_inputs();
    repeat (130) begin
      tick();
      if (full) full_seen = 1'b1;
    end
    check("wrap_full_never", full_seen, 1'b0);
    drain(300);
    check_seq("wrap_seq", sent);

    // simultaneous accept and pop
    dut_rx.delete(); sent.delete();
    for (int i = 8'h60; i <= 8'h64; i++) begin
      src.push_back(8'(i));
      sent.push_back(8'(i));
    end
    ack_mode = 0;
    drive_inputs();
    repeat (14) tick();
    check("simul_level_before", level, 5);
    src.push_back(8'h65); sent.push_back(8'h65);
    ack_mode = 4;
    out_ack = 1'b1;
    drive_inputs();
    tick();
    out_ack = 1'b0;
    check("simul_in_ack", in_ack, 1'b1);
    check("simul_level", level, 5);
    drain(200);
    check_seq("simul_seq", sent);

    // asynchronous reset in the middle of a burst
    dut_rx.delete();
    for (int i = 8'h70; i <= 8'h79; i++) src.push_back(8'(i));
    ack_mode = 0;
    drive_inputs();
    guard = 0;
    while ((memq.size() + int'(m_oen)) != 7 && guard < 40) begin
      tick();
      guard++;
    end
    check("areset_level_before", level, 7);
    #2;
    reset_ = 1'b0;
    #1;
    model_reset();
    src.delete();
    in_en = 1'b0;
    check("areset_out_en", out_en, 1'b0);
    check("areset_in_ack", in_ack, 1'b0);
    check("areset_level", level, 0);
    compare_all();
    @(negedge clk);
    reset_ = 1'b1;
    src.push_back(8'h55);
    drain(100);
    exp.delete(); exp.push_back(8'h55);
    check_seq("areset_seq", exp);

    // line-feed handling
    dut_rx.delete();
    src.push_back(8'h48); src.push_back(8'h0A); src.push_back(8'h0D);
    drain(100);
    exp.delete();
    exp.push_back(8'h48);
    if (CRLF) exp.push_back(8'h0D);
    exp.push_back(8'h0A);
    exp.push_back(8'h0D);
    check_seq("crlf_seq", exp);

    // random traffic, including out_ack while nothing is valid
    dut_rx.delete(); sent.delete();
    ack_mode = 1;
    drive_inputs();
    repeat (400) begin
      if ($urandom_range(0, 2) == 0 && src.size() < 4) begin
        b = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
        src.push_back(b);
        sent.push_back(b);
      end
      tick();
    end
    drain(400);
    check_seq("random_seq", expand(sent));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
